// File: rtl/riscvboy_decode_pkg.sv
// Shared decode-stage definitions: instruction class codes, memory op bit
// positions within the decode info bus, and the load/store unit FSM encoding.
package riscvboy_decode_pkg;

  localparam logic [2:0] TYPE_ALU = 3'b001;
  localparam logic [2:0] TYPE_BJP = 3'b010;
  localparam logic [2:0] TYPE_MEM = 3'b011;
  localparam logic [2:0] TYPE_CSR = 3'b100;

  localparam int MEM_OP_W = 8;
  localparam int MEM_LB   = 0;
  localparam int MEM_LH   = 1;
  localparam int MEM_LW   = 2;
  localparam int MEM_LBU  = 3;
  localparam int MEM_LHU  = 4;
  localparam int MEM_SB   = 5;
  localparam int MEM_SH   = 6;
  localparam int MEM_SW   = 7;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_ldext.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to the one-hot load op.
module lsu_ldext
  import riscvboy_decode_pkg::*;
(
  input  logic [MEM_OP_W-1:0] op,
  input  logic [1:0]          addr_lo,
  input  logic [31:0]         rdata,
  output logic [31:0]         data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_op;

  assign unused_op = ^{op[MEM_SW:MEM_SB], op[MEM_LW]};

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // lw (and anything not a narrow load) passes the word through untouched
  always_comb begin
    data = rdata;
    if (op[MEM_LB])       data = {{24{byte_sel[7]}}, byte_sel};
    else if (op[MEM_LBU]) data = {24'd0, byte_sel};
    else if (op[MEM_LH])  data = {{16{half_sel[15]}}, half_sel};
    else if (op[MEM_LHU]) data = {16'd0, half_sel};
  end

endmodule

// File: rtl/lsu.sv
// Execute-stage load/store unit: one outstanding access on a valid/ready
// data-memory bus, pipeline stall while busy, registered writeback/exceptions.
module lsu
  import riscvboy_decode_pkg::*;
#(
  parameter int         DECODE_INFO_BUS_WIDTH = 14,
  parameter logic [2:0] MEM_TYPE_CODE         = 3'b011
) (
  input  logic                             clk_sys,
  input  logic                             rst_sys,
  input  logic [DECODE_INFO_BUS_WIDTH-1:0] i_decode_info_bus,
  input  logic [31:0]                      i_rs1data_e,
  input  logic [31:0]                      i_rs2data_e,
  input  logic [31:0]                      i_imm_e,
  input  logic [4:0]                       i_rdidx_e,
  output logic                             o_lsu_stall,
  output logic                             o_mem_req_vld,
  input  logic                             i_mem_req_rdy,
  output logic [31:0]                      o_mem_addr,
  output logic                             o_mem_we,
  output logic [31:0]                      o_mem_wdata,
  output logic [3:0]                       o_mem_wstrb,
  input  logic                             i_mem_rsp_vld,
  input  logic [31:0]                      i_mem_rsp_rdata,
  input  logic                             i_mem_rsp_err,
  output logic                             o_wb_vld,
  output logic [4:0]                       o_wb_rdidx,
  output logic [31:0]                      o_wb_data,
  output logic                             o_misalign_exc,
  output logic                             o_bus_err_exc,
  output logic [31:0]                      o_exc_addr
);

  function automatic logic [31:0] store_wdata(input logic [MEM_OP_W-1:0] op,
                                              input logic [31:0] rs2);
    if (op[MEM_SB]) return {4{rs2[7:0]}};
    if (op[MEM_SH]) return {2{rs2[15:0]}};
    if (op[MEM_SW]) return rs2;
    return '0;
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [MEM_OP_W-1:0] op,
                                             input logic [1:0] lo);
    if (op[MEM_SB]) return 4'b0001 << lo;
    if (op[MEM_SH]) return lo[1] ? 4'b1100 : 4'b0011;
    if (op[MEM_SW]) return 4'b1111;
    return 4'b0000;
  endfunction

  lsu_state_e          state, state_nxt;
  logic [2:0]          type_code;
  logic [MEM_OP_W-1:0] op;
  logic                unused_bus;
  logic                mem_op;
  logic [31:0]         eff_addr;
  logic                misalign;
  logic                issue;
  logic                mis_hit;
  logic                req_vld;
  logic                rsp_fire;
  logic [31:0]         ld_data;

  logic [MEM_OP_W-1:0] op_p0;
  logic [31:0]         addr_p0;
  logic [4:0]          rdidx_p0;
  logic [31:0]         wdata_p0;
  logic [3:0]          wstrb_p0;

  logic                vld_p1;
  logic                berr_p1;
  logic                mis_p1;
  logic [31:0]         data_p1;
  logic [4:0]          rdidx_p1;
  logic [31:0]         exc_addr_p1;

  // ---- decode and address generation (combinational, from ID/EX) ----
  assign type_code  = i_decode_info_bus[DECODE_INFO_BUS_WIDTH-1 -: 3];
  assign op         = i_decode_info_bus[MEM_OP_W-1:0];
  assign unused_bus = ^i_decode_info_bus[DECODE_INFO_BUS_WIDTH-4:MEM_OP_W];
  assign mem_op     = (type_code == MEM_TYPE_CODE) && (|op);
  assign eff_addr   = i_rs1data_e + i_imm_e;
  assign misalign   = ((op[MEM_LH] | op[MEM_LHU] | op[MEM_SH]) & eff_addr[0])
                    | ((op[MEM_LW] | op[MEM_SW]) & (|eff_addr[1:0]));

  // Decode bus is only looked at in IDLE; a held op while busy never re-issues.
  assign issue    = (state == LSU_IDLE) && mem_op && !misalign && !rst_sys;
  assign mis_hit  = (state == LSU_IDLE) && mem_op && misalign && !rst_sys;
  assign rsp_fire = (state == LSU_WAIT) && i_mem_rsp_vld;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) state <= LSU_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (issue)          state_nxt = LSU_REQ;
      LSU_REQ:  if (i_mem_req_rdy)  state_nxt = LSU_WAIT;
      LSU_WAIT: if (i_mem_rsp_vld)  state_nxt = LSU_IDLE;
      default:                      state_nxt = LSU_IDLE;
    endcase
  end

  // Stall drops in the response cycle so ID/EX advances exactly once.
  always_comb begin
    o_lsu_stall = 1'b0;
    req_vld     = 1'b0;
    case (state)
      LSU_IDLE: o_lsu_stall = issue;
      LSU_REQ: begin
        o_lsu_stall = 1'b1;
        req_vld     = 1'b1;
      end
      LSU_WAIT: o_lsu_stall = !i_mem_rsp_vld;
      default:  o_lsu_stall = 1'b0;
    endcase
  end

  // ---- p0: request capture, held through REQ and WAIT ----
  always_ff @(posedge clk_sys) begin
    if (issue) begin
      op_p0    <= op;
      addr_p0  <= eff_addr;
      rdidx_p0 <= i_rdidx_e;
      wdata_p0 <= store_wdata(op, i_rs2data_e);
      wstrb_p0 <= store_wstrb(op, eff_addr[1:0]);
    end
  end

  assign o_mem_req_vld = req_vld;
  assign o_mem_addr    = req_vld ? addr_p0 : '0;
  assign o_mem_we      = req_vld && (|op_p0[MEM_SW:MEM_SB]);
  assign o_mem_wdata   = req_vld ? wdata_p0 : '0;
  assign o_mem_wstrb   = req_vld ? wstrb_p0 : '0;

  lsu_ldext u_ldext (
    .op      (op_p0),
    .addr_lo (addr_p0[1:0]),
    .rdata   (i_mem_rsp_rdata),
    .data    (ld_data)
  );

  // ---- p1: registered writeback and exception pulses ----
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      vld_p1  <= 1'b0;
      berr_p1 <= 1'b0;
      mis_p1  <= 1'b0;
    end else begin
      vld_p1  <= rsp_fire && !i_mem_rsp_err && (|op_p0[MEM_LHU:MEM_LB]);
      berr_p1 <= rsp_fire && i_mem_rsp_err;
      mis_p1  <= mis_hit;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rsp_fire) begin
      data_p1  <= ld_data;
      rdidx_p1 <= rdidx_p0;
    end
    if (mis_hit)       exc_addr_p1 <= eff_addr;
    else if (rsp_fire) exc_addr_p1 <= addr_p0;
  end

  assign o_wb_vld       = vld_p1;
  assign o_wb_rdidx     = vld_p1 ? rdidx_p1 : '0;
  assign o_wb_data      = vld_p1 ? data_p1 : '0;
  assign o_misalign_exc = mis_p1;
  assign o_bus_err_exc  = berr_p1;
  assign o_exc_addr     = (mis_p1 || berr_p1) ? exc_addr_p1 : '0;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, randomized transactions against a
// behavioural model, and hand sequences for no-ops and mid-access reset.
module tb_lsu;
  import riscvboy_decode_pkg::*;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic [13:0] bus;
  logic [31:0] rs1, rs2, imm;
  logic [4:0]  rdidx;
  logic        stall, req_vld, req_rdy, we, rsp_vld, rsp_err;
  logic [31:0] addr, wdata, rsp_rdata, wb_data, exc_addr;
  logic [3:0]  wstrb;
  logic        wb_vld, mis_exc, berr_exc;
  logic [4:0]  wb_rdidx;

  int checks   = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  lsu #(.DECODE_INFO_BUS_WIDTH(14), .MEM_TYPE_CODE(3'b011)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .i_decode_info_bus(bus),
    .i_rs1data_e(rs1), .i_rs2data_e(rs2), .i_imm_e(imm), .i_rdidx_e(rdidx),
    .o_lsu_stall(stall), .o_mem_req_vld(req_vld), .i_mem_req_rdy(req_rdy),
    .o_mem_addr(addr), .o_mem_we(we), .o_mem_wdata(wdata), .o_mem_wstrb(wstrb),
    .i_mem_rsp_vld(rsp_vld), .i_mem_rsp_rdata(rsp_rdata), .i_mem_rsp_err(rsp_err),
    .o_wb_vld(wb_vld), .o_wb_rdidx(wb_rdidx), .o_wb_data(wb_data),
    .o_misalign_exc(mis_exc), .o_bus_err_exc(berr_exc), .o_exc_addr(exc_addr)
  );

  typedef struct {
    int          op;
    logic [31:0] rs1, imm, rs2, rdata;
    logic [4:0]  rdidx;
    bit          err;
    int          rdy_dly, rsp_dly;
    bit          exp_mis;
    logic [31:0] exp_addr;
    bit          exp_we;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    bit          exp_wb;
    logic [31:0] exp_data;
    bit          exp_berr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(int op, logic [31:0] r1, logic [31:0] im, logic [31:0] r2,
                               logic [31:0] rd, logic [4:0] ri, bit er, int rdy, int rsp,
                               bit mis, logic [31:0] ea, bit ew, logic [31:0] ewd,
                               logic [3:0] ews, bit ewb, logic [31:0] ed, bit eb);
    vec_t v;
    v.op = op; v.rs1 = r1; v.imm = im; v.rs2 = r2; v.rdata = rd; v.rdidx = ri;
    v.err = er; v.rdy_dly = rdy; v.rsp_dly = rsp; v.exp_mis = mis; v.exp_addr = ea;
    v.exp_we = ew; v.exp_wdata = ewd; v.exp_wstrb = ews; v.exp_wb = ewb;
    v.exp_data = ed; v.exp_berr = eb;
    return v;
  endfunction

  // Reference model: access size, lane and extension derived with plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t        r = v;
    int          size, lane;
    bit          store, signd;
    logic [31:0] sh, val;
    size  = (v.op == 0 || v.op == 3 || v.op == 5) ? 1 :
            (v.op == 1 || v.op == 4 || v.op == 6) ? 2 : 4;
    store = (v.op >= 5);
    signd = (v.op == 0 || v.op == 1);
    r.exp_addr = v.rs1 + v.imm;
    lane       = int'(r.exp_addr % 4);
    r.exp_mis  = (r.exp_addr % size) != 0;
    r.exp_we   = store;
    r.exp_wstrb = store ? 4'(((1 << size) - 1) << lane) : 4'd0;
    if (size == 1)      r.exp_wdata = (v.rs2 & 32'hFF) * 32'h01010101;
    else if (size == 2) r.exp_wdata = (v.rs2 & 32'hFFFF) * 32'h00010001;
    else                r.exp_wdata = v.rs2;
    sh = v.rdata >> (8 * lane);
    if (size == 1) begin
      val = sh & 32'hFF;
      if (signd && val >= 32'h80) val = val | 32'hFFFFFF00;
    end else if (size == 2) begin
      val = sh & 32'hFFFF;
      if (signd && val >= 32'h8000) val = val | 32'hFFFF0000;
    end else val = v.rdata;
    r.exp_data = val;
    r.exp_wb   = !store && !v.err && !r.exp_mis;
    r.exp_berr = v.err && !r.exp_mis;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  stall,    0);
    chk({tag, "_req"},    req_vld,  0);
    chk({tag, "_addr"},   addr,     0);
    chk({tag, "_we"},     we,       0);
    chk({tag, "_wdata"},  wdata,    0);
    chk({tag, "_wstrb"},  wstrb,    0);
    chk({tag, "_wbvld"},  wb_vld,   0);
    chk({tag, "_wbidx"},  wb_rdidx, 0);
    chk({tag, "_wbdata"}, wb_data,  0);
    chk({tag, "_mis"},    mis_exc,  0);
    chk({tag, "_berr"},   berr_exc, 0);
    chk({tag, "_excaddr"}, exc_addr, 0);
  endtask

  // Entered a little after a rising edge; leaves 2 time units after one.
  task automatic run_txn(input vec_t v);
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_we;
    bus = {TYPE_MEM, 3'b000, 8'(1 << v.op)};
    rs1 = v.rs1; imm = v.imm; rs2 = v.rs2; rdidx = v.rdidx;
    req_rdy = 1'b0; rsp_vld = 1'b0; rsp_err = 1'b0;
    #1;
    if (v.exp_mis) begin
      chk("mis_stall", stall, 0);
      chk("mis_req", req_vld, 0);
      @(posedge clk_sys); #1; bus = '0; #1;
      chk("mis_exc", mis_exc, 1);
      chk("mis_exc_addr", exc_addr, v.exp_addr);
      chk("mis_req_after", req_vld, 0);
      chk("mis_stall_after", stall, 0);
      @(posedge clk_sys); #2;
      chk("mis_pulse_end", mis_exc, 0);
      return;
    end
    chk("issue_stall", stall, 1);
    chk("issue_req", req_vld, 0);
    @(posedge clk_sys); #1;
    c_addr = '0; c_wdata = '0; c_wstrb = '0; c_we = 1'b0;
    for (int k = 0; k <= v.rdy_dly; k++) begin
      req_rdy = (k == v.rdy_dly);
      rsp_vld = (k == 0);
      rsp_rdata = 32'hBAD0BAD0;
      #1;
      chk("req_vld", req_vld, 1);
      chk("req_stall", stall, 1);
      if (k == 0) begin
        c_addr = addr; c_wdata = wdata; c_wstrb = wstrb; c_we = we;
      end else begin
        chk("hold_addr", addr, c_addr);
        chk("hold_wdata", wdata, c_wdata);
        chk("hold_wstrb", wstrb, c_wstrb);
        chk("hold_we", we, c_we);
      end
      @(posedge clk_sys); #1;
    end
    req_rdy = 1'b0; rsp_vld = 1'b0;
    chk("req_addr", c_addr, v.exp_addr);
    chk("req_we", c_we, v.exp_we);
    chk("req_wstrb", c_wstrb, v.exp_wstrb);
    if (v.exp_we) chk("req_wdata", c_wdata, v.exp_wdata);
    for (int k = 0; k <= v.rsp_dly; k++) begin
      rsp_vld = (k == v.rsp_dly);
      rsp_err = v.err;
      rsp_rdata = v.rdata;
      #1;
      chk("wait_req", req_vld, 0);
      chk("wait_stall", stall, (k == v.rsp_dly) ? 0 : 1);
      @(posedge clk_sys); #1;
    end
    rsp_vld = 1'b0; rsp_err = 1'b0; bus = '0;
    #1;
    chk("wb_vld", wb_vld, v.exp_wb);
    if (v.exp_wb) begin
      chk("wb_data", wb_data, v.exp_data);
      chk("wb_rdidx", wb_rdidx, v.rdidx);
    end
    chk("berr_exc", berr_exc, v.exp_berr);
    if (v.exp_berr) chk("berr_addr", exc_addr, v.exp_addr);
    chk("post_stall", stall, 0);
    chk("post_mis", mis_exc, 0);
    @(posedge clk_sys); #2;
    chk("wb_pulse_end", wb_vld, 0);
    chk("berr_pulse_end", berr_exc, 0);
  endtask

  vec_t tbl[15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t r;
    tbl[0]  = mkv(2, 32'h1000, 32'd4, 0, 32'hDEADBEEF, 5, 0, 0, 1, 0, 32'h1004, 0, 0, 4'h0, 1, 32'hDEADBEEF, 0);
    tbl[1]  = mkv(0, 32'h2000, 32'd3, 0, 32'h80123456, 7, 0, 1, 0, 0, 32'h2003, 0, 0, 4'h0, 1, 32'hFFFFFF80, 0);
    tbl[2]  = mkv(3, 32'h2000, 32'd3, 0, 32'h80123456, 8, 0, 0, 2, 0, 32'h2003, 0, 0, 4'h0, 1, 32'h00000080, 0);
    tbl[3]  = mkv(6, 32'h3000, 32'd2, 32'h1234ABCD, 0, 0, 0, 3, 0, 0, 32'h3002, 1, 32'hABCDABCD, 4'hC, 0, 0, 0);
    tbl[4]  = mkv(2, 32'h4000, 32'd1, 0, 0, 0, 0, 0, 0, 1, 32'h4001, 0, 0, 4'h0, 0, 0, 0);
    tbl[5]  = mkv(7, 32'h5000, 32'd0, 32'hCAFEF00D, 0, 0, 1, 0, 1, 0, 32'h5000, 1, 32'hCAFEF00D, 4'hF, 0, 0, 1);
    tbl[6]  = mkv(1, 32'h6000, 32'd2, 0, 32'h80017FFF, 9, 0, 0, 0, 0, 32'h6002, 0, 0, 4'h0, 1, 32'hFFFF8001, 0);
    tbl[7]  = mkv(4, 32'h6000, 32'd0, 0, 32'h12348765, 10, 0, 0, 0, 0, 32'h6000, 0, 0, 4'h0, 1, 32'h00008765, 0);
    tbl[8]  = mkv(5, 32'h7000, 32'd1, 32'h000000A5, 0, 0, 0, 1, 1, 0, 32'h7001, 1, 32'hA5A5A5A5, 4'h2, 0, 0, 0);
    tbl[9]  = mkv(2, 32'h10, 32'hFFFFFFF4, 0, 32'h11223344, 0, 0, 0, 0, 0, 32'h4, 0, 0, 4'h0, 1, 32'h11223344, 0);
    tbl[10] = mkv(2, 32'hFFFFFFF0, 32'h14, 0, 32'h55AA55AA, 31, 0, 0, 0, 0, 32'h4, 0, 0, 4'h0, 1, 32'h55AA55AA, 0);
    tbl[11] = mkv(6, 32'h8000, 32'd3, 0, 0, 0, 0, 0, 0, 1, 32'h8003, 0, 0, 4'h0, 0, 0, 0);
    tbl[12] = mkv(0, 32'h9000, 32'd1, 0, 32'h0, 3, 1, 0, 0, 0, 32'h9001, 0, 0, 4'h0, 0, 0, 1);
    tbl[13] = mkv(1, 32'h6000, 32'd0, 0, 32'h00007FFE, 4, 0, 2, 0, 0, 32'h6000, 0, 0, 4'h0, 1, 32'h00007FFE, 0);
    tbl[14] = mkv(0, 32'h2000, 32'd1, 0, 32'h00007F00, 6, 0, 0, 3, 0, 32'h2001, 0, 0, 4'h0, 1, 32'h0000007F, 0);

    rst_sys = 1'b1; bus = '0; rs1 = '0; rs2 = '0; imm = '0; rdidx = '0;
    req_rdy = 1'b0; rsp_vld = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk_all_zero("reset");
    rst_sys = 1'b0;
    @(posedge clk_sys); #1;

    for (int i = 0; i < 15; i++) run_txn(tbl[i]);

    // Non-memory types and an empty memory op must not start anything.
    for (int t = 0; t < 4; t++) begin
      logic [2:0] tc;
      tc = (t == 0) ? TYPE_ALU : (t == 1) ? TYPE_BJP : (t == 2) ? TYPE_CSR : TYPE_MEM;
      bus = {tc, 3'b000, (t == 3) ? 8'h00 : 8'h04};
      rs1 = 32'h4000; imm = 32'd1;
      #1;
      chk("noop_stall", stall, 0);
      chk("noop_req", req_vld, 0);
      @(posedge clk_sys); #1;
      bus = '0; #1;
      chk("noop_mis", mis_exc, 0);
      chk("noop_req_next", req_vld, 0);
      @(posedge clk_sys); #1;
    end

    // Asynchronous reset while waiting for a response, then a stray late response.
    bus = {TYPE_MEM, 3'b000, 8'h04}; rs1 = 32'h1000; imm = 32'd8; rdidx = 5'd12;
    @(posedge clk_sys); #1;
    req_rdy = 1'b1;
    @(posedge clk_sys); #1;
    req_rdy = 1'b0; #1;
    chk("rstwait_stall_before", stall, 1);
    rst_sys = 1'b1; bus = '0; #1;
    chk_all_zero("rstwait");
    @(posedge clk_sys); #1;
    rst_sys = 1'b0;
    rsp_vld = 1'b1; rsp_rdata = 32'h13572468; #1;
    chk("late_rsp_stall", stall, 0);
    chk("late_rsp_req", req_vld, 0);
    @(posedge clk_sys); #1;
    rsp_vld = 1'b0; #1;
    chk("late_rsp_wb", wb_vld, 0);
    chk("late_rsp_berr", berr_exc, 0);
    @(posedge clk_sys); #1;
    run_txn(tbl[0]);

    for (int i = 0; i < 60; i++) begin
      r.op      = int'($urandom_range(0, 7));
      r.rs1     = $urandom;
      r.imm     = 32'($urandom_range(0, 63)) - 32'd32;
      r.rs2     = $urandom;
      r.rdata   = $urandom;
      r.rdidx   = 5'($urandom_range(0, 31));
      r.err     = ($urandom_range(0, 7) == 0);
      r.rdy_dly = int'($urandom_range(0, 3));
      r.rsp_dly = int'($urandom_range(0, 3));
      run_txn(model(r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the execute stage; consumes the memory-class decode info bus (type code 3'b011) emitted by the decode stage's ID/EX register.
- Computes the effective address and issues one access at a time on a valid/ready data-memory bus.
- Returns aligned, sign- or zero-extended load data for writeback, and stalls the pipeline via hazard control while an access is outstanding.

Parameters:
- DECODE_INFO_BUS_WIDTH, 14, width of i_decode_info_bus; type field at [13:11], op bits at [10:0].
- MEM_TYPE_CODE, 3'b011, type-field value identifying memory ops.

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst_sys  in  1  reset; asynchronous, active-high.
- i_decode_info_bus  in  14  op bits: 0=lb 1=lh 2=lw 3=lbu 4=lhu 5=sb 6=sh 7=sw; 8-10 unused; [13:11] type.
- i_rs1data_e  in  32  base register value.
- i_rs2data_e  in  32  store data.
- i_imm_e  in  32  sign-extended offset.
- i_rdidx_e  in  5  load destination index.
- o_lsu_stall  out  1  to hazard control; holds IF/ID/EX.
- o_mem_req_vld  out  1  request valid.
- i_mem_req_rdy  in  1  request accepted.
- o_mem_addr  out  32  byte address.
- o_mem_we  out  1  1=store.
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_wstrb  out  4  byte enables; 0 for loads.
- i_mem_rsp_vld  in  1  response valid (read data or write ack).
- i_mem_rsp_rdata  in  32  read word.
- i_mem_rsp_err  in  1  bus error, qualified by i_mem_rsp_vld.
- o_wb_vld  out  1  load result valid (1-cycle pulse).
- o_wb_rdidx  out  5  load destination.
- o_wb_data  out  32  extended load data.
- o_misalign_exc  out  1  misaligned access pulse.
- o_bus_err_exc  out  1  bus error pulse.
- o_exc_addr  out  32  faulting address; valid with either exception pulse.

Behaviour:
- Reset: every output is 0; FSM enters IDLE. Asynchronous reset mid-access returns to IDLE immediately, and any later stray response is ignored.
- mem_op = (type==MEM_TYPE_CODE) & |op[7:0]. The bus is one-hot by construction; type 011 with no op bit set is a no-op.
- addr = rs1 + imm, modulo 2^32 (wraps, no flag).
- Misaligned when lh/lhu/sh have addr[0]=1, or lw/sw have addr[1:0]!=0.
  - Action: no bus request, no stall.
  - Next cycle: o_misalign_exc=1 for one cycle, o_exc_addr=addr.
- FSM IDLE:
  - Aligned mem_op: latch op, addr, rdidx, wdata, wstrb; go to REQ.
  - o_lsu_stall=1 combinationally in that same cycle.
- FSM REQ:
  - o_mem_req_vld=1; addr, we, wdata and wstrb held stable until i_mem_req_rdy.
  - On handshake, go to WAIT. i_mem_rsp_vld in REQ is ignored (a response is never earlier than the cycle after accept).
- FSM WAIT: on i_mem_rsp_vld, go to IDLE.
- o_lsu_stall:
  - =1 in REQ, and in WAIT except the cycle i_mem_rsp_vld=1.
  - Drops in the response cycle so ID/EX advances exactly once.
  - The held decode bus is ignored while not in IDLE, so there is no re-issue.
- Response handling (registered, output next cycle):
  - err=1: o_bus_err_exc pulse with o_exc_addr; no writeback.
  - Load with err=0: o_wb_vld pulse, o_wb_rdidx, o_wb_data. Asserted even when rdidx=0; regfile discards x0.
  - Store: no writeback.
- Store formatting:
  - sb: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - sh: wdata={2{rs2[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - sw: wdata=rs2, wstrb=4'b1111.
- Load extraction:
  - lb/lbu: byte = rdata[8*addr[1:0] +: 8].
  - lh/lhu: half = rdata[16*addr[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- An in-flight access always completes; i_id2ex_flush is not an input. Back-to-back ops are allowed: the earliest next request is 2 cycles after the previous response.

Decomposition:
- Package riscvboy_decode_pkg holds:
  - type-code constants (ALU 001, BJP 010, MEM 011, CSR 100);
  - mem op bit positions (LB..SW);
  - FSM state encoding (IDLE/REQ/WAIT).
- The decode stage is to be migrated to the same package.
- Sub-module lsu_ldext: combinational load alignment/extension (op, addr[1:0], rdata -> data).

Test Plan:
- lw: rs1=0x1000, imm=4, rdy=1, rsp 2 cycles later with rdata=0xDEADBEEF -> req addr 0x1004, wstrb 0; stall high until the rsp cycle; next cycle wb_vld=1, data=0xDEADBEEF.
- lb / lbu: addr 0x2003, rdata=0x80xxxxxx -> lb gives 0xFFFFFF80; lbu gives 0x00000080.
- sh: addr 0x3002, rs2=0x1234ABCD -> wdata=0xABCDABCD, wstrb=1100, we=1; rdy held low 3 cycles -> req fields stable; no wb.
- Misaligned: lw at addr 0x4001 -> no req_vld; misalign_exc=1 for 1 cycle with exc_addr=0x4001; stall stays 0.
- Bus error: sw to 0x5000 with rsp_err=1 -> bus_err_exc pulse with exc_addr=0x5000, no wb; stall releases in the rsp cycle.
- Reset in WAIT: assert rst_sys mid-access -> all outputs 0 asynchronously; a late rsp_vld produces no wb_vld.
